// File: rtl/sipo_pkg.sv
// Shared constants for the serial receive/transmit datapath.
// The bit-order pair is reused by the matching serializer.
package sipo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 3;

    localparam logic ST_EMPTY   = 1'b0;
    localparam logic ST_PARTIAL = 1'b1;

    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit shift register with selectable bit order, shift enable and
// synchronous clear. Exposes the next-state value so the caller can capture
// a word together with its final bit.
module sipo_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] sh_next
);

    logic [WIDTH-1:0] sh;

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        sh_next = sh;
        if (shift_en) begin
            if (MSB_FIRST)
                sh_next = {sh[WIDTH-2:0], s_in};
            else
                sh_next = {s_in, sh[WIDTH-1:1]};
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, to avoid races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sh <= '0;
        else if (clear)
            sh <= '0;
        else
            sh <= sh_next;
    end

endmodule

// File: rtl/sipo8_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a 1-bit
// stream and hands them out through a double-buffered valid/ready port.
module sipo8_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CW        = DEF_CW,
    parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             s_valid,
    input  logic             s_in,
    input  logic             d_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    logic             st;
    logic             shift_en;
    logic             complete;
    logic             load;
    logic             drop;
    logic [WIDTH-1:0] sh_next;

    // clear wins over an incoming bit, discarding it.
    assign shift_en = s_valid && !clear;
    assign complete = shift_en && (bit_cnt == CW'(WIDTH - 1));
    assign load     = complete && (!d_valid || d_ready);
    assign drop     = complete && d_valid && !d_ready;

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .shift_en (shift_en),
        .s_in     (s_in),
        .sh_next  (sh_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= ST_EMPTY;
            bit_cnt <= '0;
        end else if (clear) begin
            st      <= ST_EMPTY;
            bit_cnt <= '0;
        end else if (shift_en) begin
            if (complete) begin
                st      <= ST_EMPTY;
                bit_cnt <= '0;
            end else begin
                st      <= ST_PARTIAL;
                bit_cnt <= (st == ST_EMPTY) ? CW'(1) : bit_cnt + CW'(1);
            end
        end
    end

    // NOTE: the output buffer is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_out   <= '0;
            d_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                d_out   <= sh_next;
                d_valid <= 1'b1;
            end else if (d_ready) begin
                d_valid <= 1'b0;
            end

            if (clear)
                overrun <= 1'b0;
            else if (drop)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sipo8_rx.sv
// Bench for sipo8_rx: MSB-first and LSB-first instances share one stimulus;
// expected words go into per-instance queues popped by handshake monitors.
module tb_sipo8_rx;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       s_valid;
    logic       s_in;
    logic       d_ready;
    logic [7:0] d_out_m, d_out_l;
    logic       d_valid_m, d_valid_l;
    logic [2:0] bit_cnt_m, bit_cnt_l;
    logic       overrun_m, overrun_l;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    sipo8_rx #(.WIDTH(8), .CW(3), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_valid(s_valid),
        .s_in(s_in), .d_ready(d_ready), .d_out(d_out_m), .d_valid(d_valid_m),
        .bit_cnt(bit_cnt_m), .overrun(overrun_m)
    );

    sipo8_rx #(.WIDTH(8), .CW(3), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_valid(s_valid),
        .s_in(s_in), .d_ready(d_ready), .d_out(d_out_l), .d_valid(d_valid_l),
        .bit_cnt(bit_cnt_l), .overrun(overrun_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (d_valid_m && d_ready) begin
            if (q_m.size() == 0) begin
                check("msb unexpected word", 32'(d_out_m), 32'hFFFF_FFFF);
            end else begin
                check("msb word", 32'(d_out_m), 32'(q_m.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (d_valid_l && d_ready) begin
            if (q_l.size() == 0) begin
                check("lsb unexpected word", 32'(d_out_l), 32'hFFFF_FFFF);
            end else begin
                check("lsb word", 32'(d_out_l), 32'(q_l.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_valid = 1'b1;
        s_in    = b;
        tick();
        s_valid = 1'b0;
        s_in    = 1'b0;
    endtask

    // Sends w[7] first; expected words are queued only when a transfer is due.
    task automatic send_word(input logic [7:0] w, input int gap_max,
                             input bit push, input bit ready_on_last);
        if (push) begin
            q_m.push_back(w);
            q_l.push_back(rev8(w));
        end
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && ready_on_last) d_ready = 1'b1;
            send_bit(w[i]);
            if (i != 0 && gap_max > 0) repeat ((i % gap_max) + 1) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_in    = 1'b0;
        d_ready = 1'b1;
        #3;
        check("reset d_valid", 32'(d_valid_m), 32'd0);
        check("reset d_out", 32'(d_out_m), 32'd0);
        check("reset bit_cnt", 32'(bit_cnt_m), 32'd0);
        check("reset overrun", 32'(overrun_l), 32'd0);
        #9 reset_n = 1'b1;
        tick();

        // Word 8'hEE back to back: valid one cycle after the 8th bit, then low.
        q_m.push_back(8'hEE);
        q_l.push_back(8'h77);
        for (int i = 7; i >= 1; i--) send_bit(i != 4 && i != 0);
        check("eee d_valid before last bit", 32'(d_valid_m), 32'd0);
        send_bit(1'b0);
        check("eee d_valid latency msb", 32'(d_valid_m), 32'd1);
        check("eee d_valid latency lsb", 32'(d_valid_l), 32'd1);
        check("eee d_out msb", 32'(d_out_m), 32'hEE);
        check("eee d_out lsb", 32'(d_out_l), 32'h77);
        tick();
        check("eee d_valid drops", 32'(d_valid_m), 32'd0);

        // Same word with gaps of 1-3 cycles; bit_cnt steps 1..7 then 0.
        q_m.push_back(8'hEE);
        q_l.push_back(8'h77);
        for (int i = 7; i >= 0; i--) begin
            send_bit(i != 4 && i != 0);
            check("gap bit_cnt msb", 32'(bit_cnt_m), 32'((8 - i) % 8));
            if (i == 0) check("gap bit_cnt lsb", 32'(bit_cnt_l), 32'd0);
            if (i != 0) repeat ((i % 3) + 1) tick();
        end
        check("gap d_out lsb", 32'(d_out_l), 32'h77);
        tick();

        // Overrun: A5 held with d_ready low, 3C dropped, clear resets the flag.
        d_ready = 1'b0;
        send_word(8'hA5, 0, 1'b0, 1'b0);
        check("ovr first word held", 32'(d_out_m), 32'hA5);
        check("ovr overrun before", 32'(overrun_m), 32'd0);
        send_word(8'h3C, 2, 1'b0, 1'b0);
        check("ovr d_out kept msb", 32'(d_out_m), 32'hA5);
        check("ovr d_out kept lsb", 32'(d_out_l), 32'hA5);
        check("ovr d_valid", 32'(d_valid_m), 32'd1);
        check("ovr overrun set msb", 32'(overrun_m), 32'd1);
        check("ovr overrun set lsb", 32'(overrun_l), 32'd1);
        repeat (2) tick();
        check("ovr overrun sticky", 32'(overrun_m), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr overrun cleared", 32'(overrun_m), 32'd0);
        check("ovr d_out after clear", 32'(d_out_m), 32'hA5);
        check("ovr d_valid after clear", 32'(d_valid_m), 32'd1);
        q_m.push_back(8'hA5);
        q_l.push_back(8'hA5);
        d_ready = 1'b1;
        tick();
        check("ovr drained", 32'(d_valid_m), 32'd0);

        // Back-to-back: 0F waiting, F0 completes on the consuming edge.
        d_ready = 1'b0;
        send_word(8'h0F, 0, 1'b1, 1'b0);
        q_m.push_back(8'hF0);
        q_l.push_back(8'h0F);
        repeat (2) tick();
        check("b2b holding 0F", 32'(d_out_m), 32'h0F);
        send_word(8'hF0, 1, 1'b0, 1'b1);
        check("b2b d_valid no bubble", 32'(d_valid_m), 32'd1);
        check("b2b d_out msb", 32'(d_out_m), 32'hF0);
        check("b2b d_out lsb", 32'(d_out_l), 32'h0F);
        check("b2b overrun", 32'(overrun_m), 32'd0);
        tick();
        check("b2b d_valid drops", 32'(d_valid_m), 32'd0);

        // Clear together with a valid bit discards the partial word and that bit.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("clr bit_cnt before", 32'(bit_cnt_m), 32'd5);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_in    = 1'b1;
        tick();
        clear   = 1'b0;
        s_valid = 1'b0;
        s_in    = 1'b0;
        check("clr bit_cnt", 32'(bit_cnt_m), 32'd0);
        check("clr d_valid", 32'(d_valid_m), 32'd0);
        send_word(8'h81, 0, 1'b1, 1'b0);
        check("clr d_out msb", 32'(d_out_m), 32'h81);
        check("clr d_out lsb", 32'(d_out_l), 32'h81);
        tick();

        // Asynchronous reset mid-word, away from any clock edge.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("arst bit_cnt before", 32'(bit_cnt_m), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        check("arst d_out msb", 32'(d_out_m), 32'd0);
        check("arst d_out lsb", 32'(d_out_l), 32'd0);
        check("arst bit_cnt", 32'(bit_cnt_m), 32'd0);
        check("arst d_valid", 32'(d_valid_m), 32'd0);
        check("arst overrun", 32'(overrun_m), 32'd0);
        #3 reset_n = 1'b1;
        tick();
        send_word(8'hEE, 0, 1'b1, 1'b0);
        check("arst recovery msb", 32'(d_out_m), 32'hEE);
        check("arst recovery lsb", 32'(d_out_l), 32'h77);
        repeat (2) tick();

        check("msb queue drained", 32'(q_m.size()), 32'd0);
        check("lsb queue drained", 32'(q_l.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
